// File: rtl/seg7_value_formatter_if.sv
// Sample-in / display-word-out bundle between the value formatter and its neighbours.
// The producer side drives samples and the formatter side drives the display word.
interface seg7_value_formatter_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        ready;
    logic [15:0] bits;
    logic        done;
    logic        over;

    modport master (
        output sample_in, sample_valid,
        input  ready, bits, done, over
    );

    modport slave (
        input  sample_in, sample_valid,
        output ready, bits, done, over
    );
endinterface

// File: rtl/seg7_value_formatter.sv
// Converts a signed hundredths sample into the "S X.YZ" nibble word for the 7-seg driver,
// saturating at +/-9.99 and holding each displayed value for HOLD_CYCLES clocks.
module seg7_value_formatter #(
    parameter int HOLD_CYCLES = 5_000_000,
    parameter int HOLD_W      = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    seg7_value_formatter_if.slave  io_fmt
);
    typedef enum logic [2:0] {S_IDLE, S_SAT, S_SHIFT, S_DONE, S_HOLD} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    state_t            r_state, w_state_next;
    logic [15:0]       r_sample;
    logic              r_neg;
    logic              r_sat;
    logic [9:0]        r_mag;
    logic [11:0]       r_bcd;
    logic [3:0]        r_iter;
    logic [HOLD_W-1:0] r_hold;
    logic [15:0]       r_bits;
    logic              r_over;
    logic              r_done;

    logic [16:0]       w_mag17;
    logic              w_sat;
    logic [9:0]        w_mag10;
    logic [11:0]       w_bcd_adj;
    logic [21:0]       w_shift;

    // 17-bit magnitude so -32768 does not wrap back to itself
    assign w_mag17 = r_sample[15] ? (17'd0 - {r_sample[15], r_sample}) : {1'b0, r_sample};
    assign w_sat   = (w_mag17 > 17'd999);
    assign w_mag10 = w_sat ? 10'd999 : w_mag17[9:0];

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < 3; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    assign w_shift = {w_bcd_adj, r_mag} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (io_fmt.sample_valid) w_state_next = S_SAT;
            S_SAT:   w_state_next = S_SHIFT;
            S_SHIFT: if (r_iter == 4'd9) w_state_next = S_DONE;
            S_DONE:  w_state_next = (HOLD_CYCLES > 0) ? S_HOLD : S_IDLE;
            S_HOLD:  if (r_hold == HOLD_LAST) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= '0;
            r_neg    <= 1'b0;
            r_sat    <= 1'b0;
            r_mag    <= '0;
            r_bcd    <= '0;
            r_iter   <= '0;
            r_hold   <= '0;
            r_bits   <= 16'hA000;
            r_over   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (io_fmt.sample_valid) r_sample <= io_fmt.sample_in;
                end
                S_SAT: begin
                    // negative zero cannot occur in two's complement, so the sign bit suffices
                    r_neg  <= r_sample[15];
                    r_sat  <= w_sat;
                    r_mag  <= w_mag10;
                    r_bcd  <= '0;
                    r_iter <= '0;
                end
                S_SHIFT: begin
                    r_bcd  <= w_shift[21:10];
                    r_mag  <= w_shift[9:0];
                    r_iter <= r_iter + 4'd1;
                end
                S_DONE: begin
                    r_bits <= {(r_neg ? 4'hB : 4'hA), r_bcd};
                    r_over <= r_sat;
                end
                S_HOLD: begin
                    if (r_hold == HOLD_LAST) r_hold <= '0;
                    else                     r_hold <= r_hold + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io_fmt.ready = (r_state == S_IDLE);
    assign io_fmt.bits  = r_bits;
    assign io_fmt.done  = r_done;
    assign io_fmt.over  = r_over;
endmodule
